// File: rtl/timer_count_ctrl_if.sv
//------------------------------------------------------------------------------
// Module      : timer_count_ctrl_if
// Description : Register-side bundle for timer_count_ctrl. Carries the control
//               inputs from the register block and the count/status outputs
//               back to it. Compare signals exist only with TMR_CMP_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface timer_count_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             tc_en;
  logic             tc_updown;
  logic [1:0]       sc_cks;
  logic             tdr_load;
  logic [WIDTH-1:0] tdr_data;
  logic             ovf_ie;
  logic             udf_ie;
  logic             clr_ovf;
  logic             clr_udf;
  logic [WIDTH-1:0] tcnt;
  logic             tick;
  logic             ovf_flag;
  logic             udf_flag;
  logic             irq;
`ifdef TMR_CMP_EN
  logic [WIDTH-1:0] tcmp;
  logic             cmp_ie;
  logic             clr_cmp;
  logic             cmp_flag;
`endif

  // Register block side: drives controls, observes count and status
  modport master (
    output tc_en, tc_updown, sc_cks, tdr_load, tdr_data,
    output ovf_ie, udf_ie, clr_ovf, clr_udf,
`ifdef TMR_CMP_EN
    output tcmp, cmp_ie, clr_cmp,
    input  cmp_flag,
`endif
    input  tcnt, tick, ovf_flag, udf_flag, irq
  );

  // Timer control side
  modport slave (
    input  tc_en, tc_updown, sc_cks, tdr_load, tdr_data,
    input  ovf_ie, udf_ie, clr_ovf, clr_udf,
`ifdef TMR_CMP_EN
    input  tcmp, cmp_ie, clr_cmp,
    output cmp_flag,
`endif
    output tcnt, tick, ovf_flag, udf_flag, irq
  );
endinterface

`default_nettype wire

// File: rtl/timer_count_ctrl.sv
//------------------------------------------------------------------------------
// Module      : timer_count_ctrl
// Description : Timer control/sequencing. Produces a single-cycle count-enable
//               tick at sc_clk/2,/4,/8,/16 and drives an up/down TCNT with
//               load, sticky overflow/underflow flags and an interrupt request.
//               Optional compare match flag enabled by macro TMR_CMP_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module timer_count_ctrl #(
  parameter int WIDTH = 8
) (
  input  wire logic          sc_clk,
  input  wire logic          sc_reset_n,
  timer_count_ctrl_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] TCNT_MAX = '1;
  localparam logic [WIDTH-1:0] TCNT_MIN = '0;

  state_t           state;
  logic [3:0]       div_cnt;
  logic [1:0]       cks_q;
  logic             tick_q;
  logic [WIDTH-1:0] tcnt_q;
  logic             ovf_q;
  logic             udf_q;

  logic [3:0]       tick_mask;
  logic             cks_change;
  logic             tick_cond;
  logic             count_en;
  logic             wrap_up;
  logic             wrap_dn;
  logic [WIDTH-1:0] tcnt_next;

  // Divider bits that must all be ones to end a prescale period
  always_comb begin
    tick_mask = 4'b0001;
    case (bus.sc_cks)
      2'b00:   tick_mask = 4'b0001;
      2'b01:   tick_mask = 4'b0011;
      2'b10:   tick_mask = 4'b0111;
      default: tick_mask = 4'b1111;
    endcase
  end

  // A prescale change or a load restarts the period, so neither may tick
  assign cks_change = (bus.sc_cks != cks_q);
  assign tick_cond  = (state == RUN) && !cks_change && !bus.tdr_load &&
                      ((div_cnt & tick_mask) == tick_mask);

  // A registered tick is honoured only while still running and enabled
  assign count_en = tick_q && (state == RUN) && bus.tc_en;
  assign wrap_up  = count_en && !bus.tdr_load && !bus.tc_updown && (tcnt_q == TCNT_MAX);
  assign wrap_dn  = count_en && !bus.tdr_load &&  bus.tc_updown && (tcnt_q == TCNT_MIN);

  // Next count: load wins over a coincident tick
  always_comb begin
    tcnt_next = tcnt_q;
    if (bus.tdr_load) begin
      tcnt_next = bus.tdr_data;
    end else if (count_en) begin
      tcnt_next = bus.tc_updown ? (tcnt_q - WIDTH'(1)) : (tcnt_q + WIDTH'(1));
    end
  end

  // Run/idle sequencing, prescale divider and tick register
  always_ff @(posedge sc_clk or negedge sc_reset_n) begin
    if (!sc_reset_n) begin
      state   <= IDLE;
      div_cnt <= 4'd0;
      cks_q   <= 2'b00;
      tick_q  <= 1'b0;
    end else begin
      cks_q  <= bus.sc_cks;
      tick_q <= tick_cond;
      case (state)
        IDLE: begin
          div_cnt <= 4'd0;
          if (bus.tc_en) state <= RUN;
        end
        default: begin
          if (!bus.tc_en) begin
            state   <= IDLE;
            div_cnt <= 4'd0;
          end else if (bus.tdr_load || cks_change) begin
            div_cnt <= 4'd0;
          end else begin
            div_cnt <= div_cnt + 4'd1;
          end
        end
      endcase
    end
  end

  // Counter and sticky flags; a set in the same cycle beats a clear
  always_ff @(posedge sc_clk or negedge sc_reset_n) begin
    if (!sc_reset_n) begin
      tcnt_q <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_next;
      ovf_q  <= wrap_up | (ovf_q & ~bus.clr_ovf);
      udf_q  <= wrap_dn | (udf_q & ~bus.clr_udf);
    end
  end

`ifdef TMR_CMP_EN
  logic cmp_q;
  logic cmp_set;

  assign cmp_set = (bus.tdr_load || count_en) && (tcnt_next == bus.tcmp);

  // Compare match flag, set when a load or tick lands on tcmp
  always_ff @(posedge sc_clk or negedge sc_reset_n) begin
    if (!sc_reset_n) begin
      cmp_q <= 1'b0;
    end else begin
      cmp_q <= cmp_set | (cmp_q & ~bus.clr_cmp);
    end
  end

  assign bus.cmp_flag = cmp_q;
  assign bus.irq      = (ovf_q & bus.ovf_ie) | (udf_q & bus.udf_ie) | (cmp_q & bus.cmp_ie);
`else
  assign bus.irq      = (ovf_q & bus.ovf_ie) | (udf_q & bus.udf_ie);
`endif

  assign bus.tcnt     = tcnt_q;
  assign bus.tick     = tick_q;
  assign bus.ovf_flag = ovf_q;
  assign bus.udf_flag = udf_q;

endmodule

`default_nettype wire

// File: doc/timer_count_ctrl.md
Name: timer_count_ctrl

Overview:
- Control and sequencing block for the timer counting datapath.
- Generates a synchronous, single-cycle count-enable tick from sc_clk at the ratio selected by sc_cks (/2, /4, /8, /16). No derived clocks are produced.
- Drives an up/down TCNT counter with load, start/stop, overflow/underflow flags and an interrupt request.
- Sits between the register interface and the counter; all logic runs on sc_clk.

Parameters:
- WIDTH, 8, bit width of TCNT and TDR (legal range 2..32).

Ports:
- sc_clk  input  1  system clock; all state updates on its rising edge
- sc_reset_n  input  1  asynchronous active-low reset
- tc_en  input  1  level; 1 = counting enabled, 0 = stopped
- tc_updown  input  1  0 = count up, 1 = count down
- sc_cks  input  2  prescale select: 00 = /2, 01 = /4, 10 = /8, 11 = /16
- tdr_load  input  1  one-cycle pulse; loads tdr_data into TCNT
- tdr_data  input  WIDTH  load value
- ovf_ie  input  1  overflow interrupt enable
- udf_ie  input  1  underflow interrupt enable
- clr_ovf  input  1  one-cycle pulse; clears ovf_flag
- clr_udf  input  1  one-cycle pulse; clears udf_flag
- tcnt  output  WIDTH  current count, registered
- tick  output  1  registered count-enable pulse, for observation
- ovf_flag  output  1  sticky overflow flag
- udf_flag  output  1  sticky underflow flag
- irq  output  1  interrupt request, combinational

Behaviour:
- Reset: sc_reset_n is asynchronous, active-low; the clock is sc_clk. While in reset, tcnt = 0, tick = 0, ovf_flag = 0, udf_flag = 0, div_cnt = 0, cks_q = 00, state = IDLE.
- FSM states: IDLE, RUN.
  - IDLE -> RUN when tc_en = 1.
  - RUN -> IDLE when tc_en = 0.
  - On entry to IDLE, div_cnt is set to 0. tcnt and the flags hold their values.
- Divider (4-bit div_cnt):
  - In RUN, div_cnt increments every cycle and wraps 15 -> 0.
  - The tick condition is that the low N bits of div_cnt are all ones, where N = sc_cks + 1.
  - The tick register captures this condition, so tick is high one cycle after the condition is met.
  - First tick after entering RUN occurs 2/4/8/16 cycles after the tc_en rising edge, for sc_cks = 00/01/10/11.
- Prescale change:
  - cks_q registers sc_cks every cycle.
  - When sc_cks != cks_q, div_cnt is set to 0 and the tick condition is forced to 0 for that cycle.
  - Counting then resumes at the full new period.
- Counter update, in priority order per cycle:
  1. tdr_load: tcnt <= tdr_data and div_cnt <= 0. A tick occurring in the same cycle is discarded. Load works in both IDLE and RUN.
  2. tick with tc_updown = 0: tcnt <= tcnt + 1. At tcnt = 2^WIDTH-1, tcnt wraps to 0 and ovf_flag is set.
  3. tick with tc_updown = 1: tcnt <= tcnt - 1. At tcnt = 0, tcnt wraps to 2^WIDTH-1 and udf_flag is set.
- Ticks are gated by state: a tick pending when tc_en drops is ignored. tcnt never changes in IDLE except by load.
- tc_updown is sampled on the tick cycle. A direction change mid-period takes effect at the next tick.
- Flags:
  - A flag is set on the cycle its wrap occurs; the set is visible one cycle after the tick.
  - Set beats clear when both happen in the same cycle.
  - clr_ovf and clr_udf act only on their own flag.
- irq = (ovf_flag & ovf_ie) | (udf_flag & udf_ie). It follows the flags with no added latency.

Optional Feature:
- Macro: TMR_CMP_EN.
- When defined:
  - Adds input tcmp [WIDTH-1:0], input cmp_ie, input clr_cmp and output cmp_flag (reset 0).
  - cmp_flag is set when a tick or load makes the next tcnt equal tcmp.
  - Set beats clr_cmp in the same cycle.
  - irq additionally ORs in (cmp_flag & cmp_ie).
- When undefined: these ports are absent and irq is as stated above.

Test Plan:
- Reset, sc_cks = 00, tc_en = 1, up -> tick every 2 cycles; tcnt = 0, 1, 2, ...; first tick 2 cycles after tc_en.
- WIDTH = 8, load 0xFE, up, sc_cks = 00 -> tcnt goes 0xFF then 0x00; ovf_flag = 1; irq = 1 only with ovf_ie = 1; clr_ovf clears the flag.
- Load 0x01, down, sc_cks = 11 -> tcnt 0x00 after 16 cycles, then 0xFF after 16 more; udf_flag = 1.
- Change sc_cks from 11 to 00 at div_cnt = 7 -> no tick for that cycle; next tick 2 cycles after the change.
- Same-cycle cases:
  - tdr_load = 0x55 coincident with a tick -> tcnt = 0x55 with no increment.
  - clr_ovf coincident with an overflow -> ovf_flag stays 1.
- Drop tc_en mid-period -> tcnt frozen. Assert sc_reset_n low mid-count -> all outputs 0 immediately, asynchronously.
